// File: rtl/n64rgb_ypbpr_conv.sv
// Three-stage, strobe-qualified converter from N64 7-bit RGB to Rec.601 YPbPr.
// Bypass mode carries RGB through the same stages so video and sync stay aligned.
module n64rgb_ypbpr_conv #(
    parameter int PIPE_STAGES   = 3,
    parameter int CHROMA_OFFSET = 64
) (
    input  logic       VCLK_i,
    input  logic       nRST_i,
    input  logic       nDSYNC_i,
    input  logic [6:0] R_i,
    input  logic [6:0] G_i,
    input  logic [6:0] B_i,
    input  logic       nCSYNC_i,
    input  logic       nYPbPr_i,
    output logic [6:0] V1_o,
    output logic [6:0] V2_o,
    output logic [6:0] V3_o,
    output logic       nCSYNC_o
);

    if (PIPE_STAGES != 3) begin : g_lat_check
        $error("n64rgb_ypbpr_conv latency is fixed at 3 strobes");
    end

    localparam logic signed [10:0] K_YR  = 11'sd306;
    localparam logic signed [10:0] K_YG  = 11'sd601;
    localparam logic signed [10:0] K_YB  = 11'sd117;
    localparam logic signed [10:0] K_PBR = -11'sd173;
    localparam logic signed [10:0] K_PBG = -11'sd339;
    localparam logic signed [10:0] K_PBB = 11'sd512;
    localparam logic signed [10:0] K_PRR = 11'sd512;
    localparam logic signed [10:0] K_PRG = -11'sd429;
    localparam logic signed [10:0] K_PRB = -11'sd83;

    localparam logic signed [18:0] ROUND = 19'sd512;
    localparam logic signed [18:0] C_OFF = 19'(CHROMA_OFFSET);

    function automatic logic signed [18:0] mul(
        input logic signed [10:0] coef,
        input logic        [6:0]  val
    );
        logic signed [18:0] ce;
        logic signed [18:0] ve;
        ce = 19'(coef);
        ve = $signed({12'd0, val});
        return ce * ve;
    endfunction

    function automatic logic [6:0] sat7(input logic signed [18:0] x);
        logic [6:0] res;
        if (x < 19'sd0)
            res = 7'd0;
        else if (x > 19'sd127)
            res = 7'd127;
        else
            res = x[6:0];
        return res;
    endfunction

    function automatic logic signed [18:0] dot(
        input logic signed [18:0] a,
        input logic signed [18:0] b,
        input logic signed [18:0] c
    );
        logic signed [18:0] s;
        s = a + b + c + ROUND;
        return s >>> 10;
    endfunction

    logic strobe;
    assign strobe = ~nDSYNC_i;

    // stage 1: raw sample
    logic [6:0] s1_r;
    logic [6:0] s1_g;
    logic [6:0] s1_b;
    logic       s1_sync;
    logic       s1_bypass;
    logic       s1_blank;

    always_ff @(posedge VCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            s1_r      <= '0;
            s1_g      <= '0;
            s1_b      <= '0;
            s1_sync   <= 1'b1;
            s1_bypass <= 1'b1;
            s1_blank  <= 1'b0;
        end else if (strobe) begin
            s1_r      <= R_i;
            s1_g      <= G_i;
            s1_b      <= B_i;
            s1_sync   <= nCSYNC_i;
            s1_bypass <= nYPbPr_i;
            s1_blank  <= ~nCSYNC_i;
        end
    end

    // stage 2: products, with pixel attributes carried alongside
    logic signed [18:0] s2_yr, s2_yg, s2_yb;
    logic signed [18:0] s2_br, s2_bg, s2_bb;
    logic signed [18:0] s2_rr, s2_rg, s2_rb;
    logic [6:0]         s2_r;
    logic [6:0]         s2_g;
    logic [6:0]         s2_b;
    logic               s2_sync;
    logic               s2_bypass;
    logic               s2_blank;

    always_ff @(posedge VCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            s2_yr     <= '0;
            s2_yg     <= '0;
            s2_yb     <= '0;
            s2_br     <= '0;
            s2_bg     <= '0;
            s2_bb     <= '0;
            s2_rr     <= '0;
            s2_rg     <= '0;
            s2_rb     <= '0;
            s2_r      <= '0;
            s2_g      <= '0;
            s2_b      <= '0;
            s2_sync   <= 1'b1;
            s2_bypass <= 1'b1;
            s2_blank  <= 1'b0;
        end else if (strobe) begin
            s2_yr     <= mul(K_YR, s1_r);
            s2_yg     <= mul(K_YG, s1_g);
            s2_yb     <= mul(K_YB, s1_b);
            s2_br     <= mul(K_PBR, s1_r);
            s2_bg     <= mul(K_PBG, s1_g);
            s2_bb     <= mul(K_PBB, s1_b);
            s2_rr     <= mul(K_PRR, s1_r);
            s2_rg     <= mul(K_PRG, s1_g);
            s2_rb     <= mul(K_PRB, s1_b);
            s2_r      <= s1_r;
            s2_g      <= s1_g;
            s2_b      <= s1_b;
            s2_sync   <= s1_sync;
            s2_bypass <= s1_bypass;
            s2_blank  <= s1_blank;
        end
    end

    // stage 3: sum, round, scale, clamp and select
    logic signed [18:0] y_sh;
    logic signed [18:0] pb_sh;
    logic signed [18:0] pr_sh;
    logic [6:0]         nxt_v1;
    logic [6:0]         nxt_v2;
    logic [6:0]         nxt_v3;

    always_comb begin
        y_sh   = dot(s2_yr, s2_yg, s2_yb);
        pb_sh  = dot(s2_br, s2_bg, s2_bb);
        pr_sh  = dot(s2_rr, s2_rg, s2_rb);
        nxt_v1 = '0;
        nxt_v2 = '0;
        nxt_v3 = '0;
        unique case (1'b1)
            (s2_blank && s2_bypass): begin
                nxt_v1 = '0;
                nxt_v2 = '0;
                nxt_v3 = '0;
            end
            (s2_blank && !s2_bypass): begin
                nxt_v1 = '0;
                nxt_v2 = sat7(C_OFF);
                nxt_v3 = sat7(C_OFF);
            end
            (!s2_blank && s2_bypass): begin
                nxt_v1 = s2_r;
                nxt_v2 = s2_g;
                nxt_v3 = s2_b;
            end
            default: begin
                nxt_v1 = sat7(y_sh);
                nxt_v2 = sat7(pb_sh + C_OFF);
                nxt_v3 = sat7(pr_sh + C_OFF);
            end
        endcase
    end

    always_ff @(posedge VCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            V1_o     <= '0;
            V2_o     <= '0;
            V3_o     <= '0;
            nCSYNC_o <= 1'b1;
        end else if (strobe) begin
            V1_o     <= nxt_v1;
            V2_o     <= nxt_v2;
            V3_o     <= nxt_v3;
            nCSYNC_o <= s2_sync;
        end
    end

endmodule

// File: tb/tb_n64rgb_ypbpr_conv.sv
// Scoreboard bench for n64rgb_ypbpr_conv: stimulus queues hand-computed results,
// a monitor retires one per strobe once the 3-strobe pipeline is full.
module tb_n64rgb_ypbpr_conv;

    typedef struct packed {
        logic [6:0] v1;
        logic [6:0] v2;
        logic [6:0] v3;
        logic       sync;
    } exp_t;

    localparam exp_t RST_EXP = '{v1: 7'd0, v2: 7'd0, v3: 7'd0, sync: 1'b1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       dsync_n = 1'b1;
    logic [6:0] r = '0;
    logic [6:0] g = '0;
    logic [6:0] b = '0;
    logic       csync_n = 1'b1;
    logic       bypass = 1'b0;
    logic [6:0] v1;
    logic [6:0] v2;
    logic [6:0] v3;
    logic       csync_o;

    exp_t q[$];
    exp_t cur = RST_EXP;
    int   n_strobe = 0;
    int   tests = 0;
    int   fails = 0;
    bit   armed = 1'b0;
    bit   done = 1'b0;

    n64rgb_ypbpr_conv dut (
        .VCLK_i   (clk),
        .nRST_i   (rst_n),
        .nDSYNC_i (dsync_n),
        .R_i      (r),
        .G_i      (g),
        .B_i      (b),
        .nCSYNC_i (csync_n),
        .nYPbPr_i (bypass),
        .V1_o     (v1),
        .V2_o     (v2),
        .V3_o     (v3),
        .nCSYNC_o (csync_o)
    );

    always #5 clk = ~clk;

    // retire the expected value for each strobe once the pipe is full
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            n_strobe = 0;
            cur = RST_EXP;
            armed = 1'b1;
        end else if (!dsync_n) begin
            n_strobe++;
            if (n_strobe >= 3) begin
                if (q.size() > 0) begin
                    cur = q.pop_front();
                end else begin
                    tests++;
                    fails++;
                    $display("FAIL underflow: strobe %0d with empty scoreboard", n_strobe);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed && !done) begin
            tests++;
            if ({v1, v2, v3, csync_o} !== cur) begin
                fails++;
                $display("FAIL out t=%0t strobe=%0d: got %0d,%0d,%0d sync=%b want %0d,%0d,%0d sync=%b",
                         $time, n_strobe, v1, v2, v3, csync_o,
                         cur.v1, cur.v2, cur.v3, cur.sync);
            end
        end
    end

    task automatic send(
        input logic [6:0] ri, input logic [6:0] gi, input logic [6:0] bi,
        input logic si, input logic mi,
        input logic [6:0] e1, input logic [6:0] e2, input logic [6:0] e3,
        input int gap
    );
        exp_t e;
        r = ri;
        g = gi;
        b = bi;
        csync_n = si;
        bypass = mi;
        dsync_n = 1'b0;
        e = '{v1: e1, v2: e2, v3: e3, sync: si};
        q.push_back(e);
        @(posedge clk);
        #1;
        if (gap > 0) begin
            dsync_n = 1'b1;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        dsync_n = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // white, strobe every 4th cycle
        for (int i = 0; i < 4; i++)
            send(127, 127, 127, 1, 0, 127, 64, 64, 3);
        send(0, 0, 127, 1, 0, 15, 127, 54, 3);
        send(127, 0, 0, 1, 0, 38, 43, 127, 3);
        send(100, 50, 20, 1, 0, 62, 41, 91, 1);

        // sync-blanked run, back-to-back strobes
        for (int i = 0; i < 5; i++)
            send(100, 50, 20, 0, 0, 0, 64, 64, 0);
        send(100, 50, 20, 1, 0, 62, 41, 91, 0);

        // mode switch between adjacent pixels
        send(127, 127, 127, 1, 0, 127, 64, 64, 1);
        send(10, 20, 30, 1, 1, 10, 20, 30, 1);
        send(10, 20, 30, 0, 1, 0, 0, 0, 1);
        send(127, 0, 0, 1, 1, 127, 0, 0, 2);
        send(0, 0, 0, 1, 0, 0, 64, 64, 2);
        send(0, 0, 0, 1, 0, 0, 64, 64, 2);

        // reset with pixels in flight
        send(0, 0, 127, 1, 0, 15, 127, 54, 1);
        send(127, 0, 0, 1, 0, 38, 43, 127, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        send(0, 0, 127, 1, 0, 15, 127, 54, 2);
        send(1, 2, 3, 1, 1, 1, 2, 3, 2);
        send(127, 0, 0, 1, 0, 38, 43, 127, 2);
        send(0, 0, 0, 1, 0, 0, 64, 64, 2);
        send(0, 0, 0, 1, 0, 0, 64, 64, 2);
        idle(3);

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
